// File: rtl/reset_sequencer.sv
// Reset sequencer: turns the system reset and software reset requests into a timed
// active-low reset for the downstream block, with settle, lockout and request accounting.
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             sw_rst_req,
  output logic             sub_reset_l,
  output logic             busy,
  output logic             done,
  output logic             req_dropped,
  output logic [CNT_W-1:0] rst_count
);

  localparam int MAX_HS  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_HS > LOCKOUT_CYCLES) ? MAX_HS : LOCKOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Terminal counts; a zero-length phase is skipped entirely, so its value is unused.
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LOCK_LAST   = CW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_SETTLE,
    ST_LOCK,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_d, busy_d, done_d, drop_d;
  logic [CNT_W-1:0] count_d;
  logic             go_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    sub_d    = sub_reset_l;
    busy_d   = busy;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    count_d  = rst_count;
    go_ready = 1'b0;

    case (state_q)
      ST_HOLD: begin
        drop_d = sw_rst_req;
        if (cnt_q == HOLD_LAST) begin
          sub_d = 1'b1;
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) go_ready = 1'b1;
          else                    state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        drop_d = sw_rst_req;
        if (cnt_q == SETTLE_LAST) go_ready = 1'b1;
      end
      ST_LOCK: begin
        drop_d = sw_rst_req;
        if (cnt_q == LOCK_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (sw_rst_req) begin
          state_d = ST_HOLD;
          sub_d   = 1'b0;
          busy_d  = 1'b1;
          if (rst_count != '1) count_d = rst_count + CNT_W'(1);
        end
      end
    endcase

    // Ready transition is shared by SETTLE expiry and a HOLD expiry with no settle window.
    if (go_ready) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      cnt_d   = '0;
      state_d = (LOCKOUT_CYCLES == 0) ? ST_RUN : ST_LOCK;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      sub_reset_l <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      req_dropped <= 1'b0;
      rst_count   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_reset_l <= sub_d;
      busy        <= busy_d;
      done        <= done_d;
      req_dropped <= drop_d;
      rst_count   <= count_d;
    end
  end

endmodule
